// File: rtl/midori64_sbox_sched_pkg.sv
// Shared definitions for the serialized Midori64 TI datapath sequencer:
// default geometry and FSM state encodings.
package midori64_sbox_sched_pkg;

    localparam int NUM_ROUNDS_DEF  = 16;
    localparam int NIBBLES_DEF     = 16;
    localparam int SBOX_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SBOX  = 3'd2,
        ST_LIN   = 3'd3,
        ST_FINAL = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_t;

endpackage

// File: rtl/midori64_sbox_sched.sv
// Control sequencer for the serialized Midori64 TI datapath: feeds nibbles through
// the pipelined shared S-box and schedules write-back, linear layer and whitening.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | plaintext XOR whitening key loaded into the state
// SBOX  | nibbles enter the S-box; results written back SBOX_STAGES cycles later
// LIN   | ShuffleCell, MixColumn, round key and constant for the current round
// FINAL | final whitening key add
// DONE  | ciphertext valid, one-cycle pulse
module midori64_sbox_sched
    import midori64_sbox_sched_pkg::*;
#(
    parameter int NUM_ROUNDS  = NUM_ROUNDS_DEF,
    parameter int NIBBLES     = NIBBLES_DEF,
    parameter int SBOX_STAGES = SBOX_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       state_load,
    output logic       sbox_in_en,
    output logic [3:0] nib_sel,
    output logic       sbox_wr_en,
    output logic [3:0] wr_sel,
    output logic       lin_en,
    output logic [3:0] round,
    output logic       final_en
);

    localparam int PHASES = NIBBLES + SBOX_STAGES;
    localparam int PW     = $clog2(PHASES);

    localparam logic [PW-1:0] NIB_P   = PW'(NIBBLES);
    localparam logic [PW-1:0] STG_P   = PW'(SBOX_STAGES);
    localparam logic [PW-1:0] LAST_P  = PW'(PHASES - 1);
    localparam logic [3:0]    RND_MAX = 4'(NUM_ROUNDS - 1);

    sched_state_t  state;
    logic [PW-1:0] phase;
    logic [PW-1:0] phase_nxt;
    logic          in_en_nxt;
    logic          wr_en_nxt;
    logic [3:0]    nib_nxt;
    logic [3:0]    wr_nxt;

    // Outputs are registered, so decode the phase about to be entered.
    always_comb begin
        phase_nxt = (state == ST_SBOX) ? phase + PW'(1) : '0;
        in_en_nxt = (phase_nxt < NIB_P);
        wr_en_nxt = (phase_nxt >= STG_P);
        nib_nxt   = in_en_nxt ? 4'(phase_nxt) : 4'd0;
        wr_nxt    = wr_en_nxt ? 4'(phase_nxt - STG_P) : 4'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            phase      <= '0;
            round      <= 4'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            state_load <= 1'b0;
            sbox_in_en <= 1'b0;
            nib_sel    <= 4'd0;
            sbox_wr_en <= 1'b0;
            wr_sel     <= 4'd0;
            lin_en     <= 1'b0;
            final_en   <= 1'b0;
        end else begin
            done       <= 1'b0;
            state_load <= 1'b0;
            sbox_in_en <= 1'b0;
            nib_sel    <= 4'd0;
            sbox_wr_en <= 1'b0;
            wr_sel     <= 4'd0;
            lin_en     <= 1'b0;
            final_en   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        state_load <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                ST_LOAD, ST_LIN: begin
                    if (state == ST_LIN && round < RND_MAX)
                        round <= round + 4'd1;
                    state      <= ST_SBOX;
                    phase      <= '0;
                    sbox_in_en <= in_en_nxt;
                    nib_sel    <= nib_nxt;
                    sbox_wr_en <= wr_en_nxt;
                    wr_sel     <= wr_nxt;
                end
                ST_SBOX: begin
                    if (phase == LAST_P) begin
                        phase <= '0;
                        if (round < RND_MAX) begin
                            state  <= ST_LIN;
                            lin_en <= 1'b1;
                        end else begin
                            state    <= ST_FINAL;
                            final_en <= 1'b1;
                        end
                    end else begin
                        phase      <= phase_nxt;
                        sbox_in_en <= in_en_nxt;
                        nib_sel    <= nib_nxt;
                        sbox_wr_en <= wr_en_nxt;
                        wr_sel     <= wr_nxt;
                    end
                end
                ST_FINAL: begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    round <= 4'd0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    round <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_midori64_sbox_sched.sv
// Self-checking bench: three sequencers (SBOX_STAGES 2, 1, 3) against a timeline model.
module tb_midori64_sbox_sched;

    localparam int NR = 16;
    localparam int NB = 16;
    localparam int STG [3] = '{2, 1, 3};

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    always #5 clk = ~clk;

    logic       busy_w  [3];
    logic       done_w  [3];
    logic       load_w  [3];
    logic       inen_w  [3];
    logic [3:0] nib_w   [3];
    logic       wren_w  [3];
    logic [3:0] wrs_w   [3];
    logic       lin_w   [3];
    logic [3:0] rnd_w   [3];
    logic       fin_w   [3];
    logic [18:0] obs    [3];

    midori64_sbox_sched #(.SBOX_STAGES(2)) dut0 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[0]), .done(done_w[0]),
        .state_load(load_w[0]), .sbox_in_en(inen_w[0]), .nib_sel(nib_w[0]),
        .sbox_wr_en(wren_w[0]), .wr_sel(wrs_w[0]), .lin_en(lin_w[0]),
        .round(rnd_w[0]), .final_en(fin_w[0]));
    midori64_sbox_sched #(.SBOX_STAGES(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[1]), .done(done_w[1]),
        .state_load(load_w[1]), .sbox_in_en(inen_w[1]), .nib_sel(nib_w[1]),
        .sbox_wr_en(wren_w[1]), .wr_sel(wrs_w[1]), .lin_en(lin_w[1]),
        .round(rnd_w[1]), .final_en(fin_w[1]));
    midori64_sbox_sched #(.SBOX_STAGES(3)) dut2 (
        .clk(clk), .rst(rst), .start(start), .busy(busy_w[2]), .done(done_w[2]),
        .state_load(load_w[2]), .sbox_in_en(inen_w[2]), .nib_sel(nib_w[2]),
        .sbox_wr_en(wren_w[2]), .wr_sel(wrs_w[2]), .lin_en(lin_w[2]),
        .round(rnd_w[2]), .final_en(fin_w[2]));

    for (genvar g = 0; g < 3; g++) begin : g_pack
        assign obs[g] = {busy_w[g], done_w[g], load_w[g], inen_w[g], nib_w[g],
                         wren_w[g], wrs_w[g], lin_w[g], rnd_w[g], fin_w[g]};
    end

    int checks = 0;
    int errors = 0;
    int fail_prints = 0;

    // Model: k = cycles since the state_load cycle, -1 when idle.
    int k [3] = '{-1, -1, -1};
    bit mvalid = 1'b0;

    function automatic int done_k(input int s);
        return 1 + (NR - 1) * (NB + s + 1) + (NB + s) + 1;
    endfunction

    function automatic logic [18:0] pack_out(input bit b, input bit d, input bit ld,
            input bit ie, input int nib, input bit we, input int wr, input bit ln,
            input int rd, input bit fe);
        return {b, d, ld, ie, 4'(nib), we, 4'(wr), ln, 4'(rd), fe};
    endfunction

    function automatic logic [18:0] expect_out(input int kk, input int s);
        int len, j, r, o, p;
        len = NB + s + 1;
        if (kk < 0) return '0;
        if (kk == 0) return pack_out(1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        j = kk - 1;
        r = j / len;
        o = j % len;
        if (r >= NR - 1) begin
            r = NR - 1;
            o = j - (NR - 1) * len;
        end
        if (o < NB + s) begin
            p = o;
            return pack_out(1, 0, 0, p < NB, (p < NB) ? p : 0,
                            p >= s, (p >= s) ? p - s : 0, 0, r, 0);
        end
        if (r < NR - 1) return pack_out(1, 0, 0, 0, 0, 0, 0, 1, r, 0);
        if (o == NB + s) return pack_out(1, 0, 0, 0, 0, 0, 0, 0, r, 1);
        return pack_out(1, 1, 0, 0, 0, 0, 0, 0, r, 0);
    endfunction

    always @(posedge clk) begin
        if (rst) mvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (rst)                      k[i] = -1;
            else if (k[i] < 0)            k[i] = start ? 0 : -1;
            else if (k[i] == done_k(STG[i])) k[i] = -1;
            else                          k[i] = k[i] + 1;
        end
    end

    always @(negedge clk) begin
        logic [18:0] e;
        if (mvalid) begin
            for (int i = 0; i < 3; i++) begin
                e = expect_out(k[i], STG[i]);
                checks++;
                if (obs[i] !== e) begin
                    errors++;
                    if (fail_prints < 20) begin
                        fail_prints++;
                        $display("FAIL cycle_cmp dut%0d k=%0d got %h expected %h", i, k[i], obs[i], e);
                    end
                end
            end
        end
    end

    // Observation monitor for literal latency pins.
    int cyc = 0;
    int load_cyc [3], lat [3], done_cnt [3], last_done [3], prev_done [3];
    int lin_cnt [3], first_in [3], first_wr [3];
    initial for (int i = 0; i < 3; i++) begin
        load_cyc[i] = 0; lat[i] = 0; done_cnt[i] = 0; last_done[i] = 0;
        prev_done[i] = 0; lin_cnt[i] = 0; first_in[i] = -1; first_wr[i] = -1;
    end
    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < 3; i++) begin
            if (load_w[i] === 1'b1) begin
                load_cyc[i] = cyc; first_in[i] = -1; first_wr[i] = -1;
            end
            if (inen_w[i] === 1'b1 && first_in[i] < 0) first_in[i] = cyc;
            if (wren_w[i] === 1'b1 && first_wr[i] < 0) first_wr[i] = cyc;
            if (lin_w[i] === 1'b1) lin_cnt[i]++;
            if (done_w[i] === 1'b1) begin
                lat[i] = cyc - load_cyc[i];
                done_cnt[i]++;
                prev_done[i] = last_done[i];
                last_done[i] = cyc;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic wait_done(input int i, input int base, input int lim);
        int n;
        n = 0;
        while (done_cnt[i] <= base && n < lim) begin
            tick(1);
            n++;
        end
        if (done_cnt[i] <= base) begin
            errors++;
            $display("FAIL wait_done dut%0d timed out after %0d cycles", i, lim);
        end
    endtask

    initial begin
        int base;
        rst = 1'b1;
        start = 1'b1;
        tick(3);
        chk("reset_outputs", int'(obs[0]), 0);
        chk("reset_outputs_s1", int'(obs[1]), 0);
        rst = 1'b0;
        start = 1'b0;
        tick(2);
        chk("idle_after_reset", int'(busy_w[0]), 0);

        // Nominal single run on all three geometries.
        for (int i = 0; i < 3; i++) lin_cnt[i] = 0;
        base = done_cnt[2];
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(2, base, 400);
        tick(2);
        chk("latency_s2", lat[0], 305);
        chk("latency_s1", lat[1], 289);
        chk("latency_s3", lat[2], 321);
        chk("lin_pulses_s2", lin_cnt[0], 15);
        chk("lin_pulses_s3", lin_cnt[2], 15);
        chk("wb_lag_s2", first_wr[0] - first_in[0], 2);
        chk("wb_lag_s1", first_wr[1] - first_in[1], 1);
        chk("wb_lag_s3", first_wr[2] - first_in[2], 3);
        tick(3);

        // start held high: the DONE cycle ignores it, the following IDLE accepts it.
        base = done_cnt[0];
        start = 1'b1;
        tick(400);
        start = 1'b0;
        tick(300);
        chk("held_start_runs", done_cnt[0] - base, 2);
        chk("held_start_gap", last_done[0] - prev_done[0], 307);

        // Reset mid-run discards the run; a fresh start takes the full latency.
        tick(5);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(150);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("rst_midrun_busy", int'(busy_w[0]), 0);
        chk("rst_midrun_round", int'(rnd_w[0]), 0);
        base = done_cnt[0];
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done(0, base, 400);
        tick(1);
        chk("latency_after_rst", lat[0], 305);

        // Random start/rst traffic, checked cycle by cycle against the model.
        for (int n = 0; n < 4000; n++) begin
            start = ($urandom_range(0, 29) == 0);
            rst   = ($urandom_range(0, 599) == 0);
            tick(1);
        end
        rst = 1'b0;
        start = 1'b0;
        tick(400);
        chk("final_idle", int'(busy_w[2]), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
